clint_int_source: RTL

- Machine-level timer and software interrupt source: the requesting end of the core's interrupt req/ack handshake.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp register and an msip bit, all accessible over a simple 32-bit register port.
- Drives level requests all_intif_int_timer_req and all_intif_int_software_req.
- Retires each request on the one-cycle ack pulse the core issues when it commits the trap.

---
 rtl/clint_int_source.sv | 112 +++++++++++
 1 files changed

// File: rtl/clint_int_source.sv
// Machine timer / software interrupt source: mtime, mtimecmp and msip behind a
// 32-bit register port, raising level requests that the core retires with ack pulses.
module clint_int_source #(
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_req_valid,
  input  logic        reg_write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        all_intif_int_timer_req,
  output logic        all_intif_int_software_req,
  input  logic        intif_all_int_timer_ack,
  input  logic        intif_all_int_software_ack
);

  localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ARMED, REQ, DONE} timer_state_t;

  timer_state_t   state_q, state_d;
  logic [63:0]    mtime;
  logic [63:0]    mtimecmp;
  logic           msip;
  logic [PW-1:0]  prescaler;
  logic [31:0]    rd_mux;
  logic           wr, rd, tick, cmp_hit;
  logic           wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;

  assign wr         = reg_req_valid & reg_write;
  assign rd         = reg_req_valid & ~reg_write;
  assign wr_msip    = wr & (reg_addr == 5'h00);
  assign wr_cmp_lo  = wr & (reg_addr == 5'h08);
  assign wr_cmp_hi  = wr & (reg_addr == 5'h0C);
  assign wr_time_lo = wr & (reg_addr == 5'h10);
  assign wr_time_hi = wr & (reg_addr == 5'h14);
  assign tick       = (prescaler == PS_LAST);
  assign cmp_hit    = (mtime >= mtimecmp);

  always_comb begin
    rd_mux = 32'h0;
    case (reg_addr)
      5'h00:   rd_mux = {31'b0, msip};
      5'h08:   rd_mux = mtimecmp[31:0];
      5'h0C:   rd_mux = mtimecmp[63:32];
      5'h10:   rd_mux = mtime[31:0];
      5'h14:   rd_mux = mtime[63:32];
      default: rd_mux = 32'h0;
    endcase
  end

  // A software write to mtime restarts the prescaler so the next tick is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= 64'h0;
      prescaler <= '0;
    end else if (wr_time_lo || wr_time_hi) begin
      prescaler <= '0;
      if (wr_time_lo) mtime[31:0]  <= reg_wdata;
      if (wr_time_hi) mtime[63:32] <= reg_wdata;
    end else if (tick) begin
      prescaler <= '0;
      mtime     <= mtime + 64'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp   <= MTIMECMP_RST;
      msip       <= 1'b0;
      reg_rdata  <= 32'h0;
      reg_rvalid <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= reg_wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= reg_wdata;
      if (wr_msip)
        msip <= reg_wdata[0];
      else if (intif_all_int_software_ack)
        msip <= 1'b0;
      reg_rvalid <= rd;
      if (rd) reg_rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARMED;
    else        state_q <= state_d;
  end

  // DONE is left only by reprogramming mtimecmp, so a wrap of mtime cannot re-raise the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (cmp_hit) state_d = REQ;
      REQ:     if (intif_all_int_timer_ack) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = ARMED;
    endcase
    if (wr_cmp_lo || wr_cmp_hi) state_d = ARMED;
  end

  assign all_intif_int_timer_req    = (state_q == REQ);
  assign all_intif_int_software_req = msip;

endmodule
